// File: rtl/xm23_fetch_pkg.sv
// XM23 fetch stage shared types and constants.
package xm23_fetch_pkg;

  typedef enum logic [1:0] {S_RESET, S_RUN, S_STALL, S_FLUSH} fetch_state_t;

  localparam logic [15:0] PC_STEP         = 16'd2;
  localparam logic [15:0] BUBBLE_INST_DEF = 16'h4C00;  // MOV R0,R0

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/xm23_fetch_stage_skid.sv
// One-entry holding register for a read that returns while decode is stalled.
module fetch_skid_buffer
  import xm23_fetch_pkg::*;
(
  input  logic         clk_in,
  input  logic         reset,
  input  logic         load_i,
  input  logic         drain_i,
  input  logic         flush_i,
  input  fetch_entry_t entry_i,
  output fetch_entry_t entry_o,
  output logic         valid_o
);

  fetch_entry_t entry_q;
  logic         valid_q;

  // Flush beats load beats drain; load and drain never coincide in practice.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      entry_q <= '0;
      valid_q <= 1'b0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      entry_q <= entry_i;
      valid_q <= 1'b1;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign entry_o = entry_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/xm23_fetch_stage.sv
// XM23 instruction fetch: owns the PC, drives the synchronous imem, and
// presents one registered instruction per cycle to decode.
module xm23_fetch_stage
  import xm23_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [15:0] BUBBLE_INST = BUBBLE_INST_DEF
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic        imem_en,
  output logic [14:0] imem_addr,
  input  logic [15:0] imem_rdata,
  output logic [15:0] inst,
  output logic        inst_valid,
  output logic [15:0] inst_pc,
  output logic [15:0] pc
);

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q;
  logic         infl_q;      // a read was issued on the previous edge
  logic [15:0]  infl_pc_q;   // byte PC of that read
  logic [15:0]  inst_q, ipc_q;
  logic         valid_q;

  fetch_entry_t skid_entry;
  logic         skid_valid, skid_load, skid_drain;

  // State register.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) state_q <= S_RESET;
    else       state_q <= state_d;
  end

  // Next state; redirect outranks stall.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RESET:        state_d = redirect ? S_FLUSH : S_RUN;
      S_RUN, S_STALL: state_d = redirect ? S_FLUSH : (stall ? S_STALL : S_RUN);
      S_FLUSH:        state_d = S_RUN;
      default:        state_d = S_RESET;
    endcase
  end

  // Issue whenever fetching is allowed and decode is free; leaving S_STALL
  // issues on the same cycle the skid drains, so there is no bubble.
  always_comb begin
    imem_en = 1'b0;
    if (state_q == S_RUN || state_q == S_STALL)
      imem_en = !stall && !redirect;
  end

  // A returning read that decode cannot take is parked; only one read is in
  // flight, so the skid never holds more than one entry.
  assign skid_load  = stall && !redirect && infl_q;
  assign skid_drain = !stall && !redirect;

  fetch_skid_buffer u_skid (
    .clk_in  (clk_in),
    .reset   (reset),
    .load_i  (skid_load),
    .drain_i (skid_drain),
    .flush_i (redirect),
    .entry_i ('{inst: imem_rdata, pc: infl_pc_q}),
    .entry_o (skid_entry),
    .valid_o (skid_valid)
  );

  // PC, in-flight tracking and the decode-facing output register.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      infl_q    <= 1'b0;
      infl_pc_q <= '0;
      inst_q    <= BUBBLE_INST;
      ipc_q     <= '0;
      valid_q   <= 1'b0;
    end else if (redirect) begin
      // Discard whatever is in flight; bit 0 of the target is forced low.
      pc_q    <= redirect_pc & 16'hFFFE;
      infl_q  <= 1'b0;
      inst_q  <= BUBBLE_INST;
      valid_q <= 1'b0;
    end else begin
      infl_q <= imem_en;
      if (imem_en) begin
        pc_q      <= pc_q + PC_STEP;
        infl_pc_q <= pc_q;
      end
      if (!stall) begin
        if (skid_valid) begin
          inst_q  <= skid_entry.inst;
          ipc_q   <= skid_entry.pc;
          valid_q <= 1'b1;
        end else if (infl_q) begin
          inst_q  <= imem_rdata;
          ipc_q   <= infl_pc_q;
          valid_q <= 1'b1;
        end else begin
          inst_q  <= BUBBLE_INST;
          valid_q <= 1'b0;
        end
      end
    end
  end

  assign imem_addr  = pc_q[15:1];
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_valid = valid_q;
  assign inst_pc    = ipc_q;

endmodule

// File: doc/xm23_fetch_stage.md
# xm23_fetch_stage

Instruction fetch stage for the XM23 pipeline. It is the producer end of the `inst` interface that the decode stage consumes. It owns the program counter, drives a synchronous instruction memory, and presents one 16-bit instruction per cycle to decode. It holds under pipeline-controller stall and flushes and redirects on a taken branch. It replaces the constant instruction currently tied into decode's `inst` input.

## Interface
Parameters:
- `RESET_PC`, 16'h0000: byte address of the first fetch after reset.
- `BUBBLE_INST`, 16'h4C00: encoding driven on `inst` whenever `inst_valid`=0 (MOV R0,R0).

Ports:
- `clk_in`  in  1  system clock.
- `reset`  in  1  **reset reset, asynchronous, active-high; clock clk_in**.
- `stall`  in  1  decode cannot accept; OR-reduction of the pipeline-controller stall vector.
- `redirect`  in  1  taken branch/jump; flushes the stage.
- `redirect_pc`  in  16  new byte PC; bit 0 ignored (treated as 0).
- `imem_en`  out  1  instruction memory read enable.
- `imem_addr`  out  15  word address, equal to the issuing PC[15:1].
- `imem_rdata`  in  16  read data, valid exactly 1 cycle after `imem_en`.
- `inst`  out  16  instruction to decode.
- `inst_valid`  out  1  `inst` holds a real instruction.
- `inst_pc`  out  16  byte address of `inst`.
- `pc`  out  16  next byte address to be issued.

## Operation
FSM states:
- S_RESET:
  - Entered on reset.
  - One idle cycle with `imem_en`=0.
  - Moves to S_FLUSH if `redirect`, otherwise to S_RUN.
- S_RUN:
  - `imem_en` = !stall & !redirect.
  - On an issue edge, `pc` <= `pc`+2. Wraps 16'hFFFE→16'h0000.
  - The in-flight flag and in-flight PC are set.
  - Moves to S_STALL on `stall`, and to S_FLUSH on `redirect`.
- S_STALL:
  - `imem_en`=0. `pc`, `inst`, `inst_valid` and `inst_pc` hold.
  - A read in flight from the previous cycle is captured into the skid entry: data plus PC, `skid_valid`<=1.
  - Returns to S_RUN when `stall`=0. Moves to S_FLUSH on `redirect`.
- S_FLUSH:
  - Entered on the edge where `redirect`=1.
  - On that edge: `pc`<={redirect_pc[15:1],1'b0}, in-flight flag cleared, `skid_valid`<=0, `inst_valid`<=0, `inst`<=BUBBLE_INST.
  - In S_FLUSH, `imem_en`=0 and `imem_rdata` is ignored.
  - Always moves to S_RUN.
- Output register update on an edge where `stall`=0 and `redirect`=0, in priority order:
  - Skid entry, if valid.
  - Else the in-flight read data.
  - Else the bubble (`inst_valid`=0).
- Skid depth is 1. At most one read is ever in flight, so overflow is impossible; the bench asserts it never occurs.
- Simultaneous events:
  - `redirect` has priority over `stall`.
  - `stall` and skid drain in the same cycle: hold. Drain happens on the first non-stall edge, and a new fetch issues in that same cycle.
- Reset mid-operation: all state is cleared immediately and asynchronously. The in-flight read is discarded.

## Timing
- Reset values:
  - `imem_en`=0, `imem_addr`=RESET_PC[15:1].
  - `inst`=BUBBLE_INST, `inst_valid`=0, `inst_pc`=0.
  - `pc`=RESET_PC, state S_RESET, `skid_valid`=0.
- Latency from issue cycle to `inst` visible: 2 cycles (memory 1, output register 1).
- Throughput: 1 instruction per cycle with no stall.
- After reset release: first `imem_en` in cycle 1. First `inst_valid`=1 in cycle 3.
- Redirect in cycle R:
  - Fetch of `redirect_pc` issues in R+2.
  - The instruction appears in R+4.
  - `inst_valid`=0 in R+1..R+3.
- `stall` is sampled every edge. Output registers change only on non-stall edges or on redirect.

## Structure
- Package `xm23_fetch_pkg`:
  - `fetch_state_t` enum {S_RESET, S_RUN, S_STALL, S_FLUSH}.
  - `PC_STEP`=2.
  - Default BUBBLE_INST constant.
  - `fetch_entry_t` struct {inst[15:0], pc[15:0]}.
- One sub-module, `fetch_skid_buffer`: one-entry `fetch_entry_t` holding register with load, drain and flush, plus a valid flag.
- Top-level integration:
  - The top level drives `stall` from `|stall_wire` and feeds `inst` into decode.
  - Decode treats BUBBLE_INST as a no-op.

## Test plan
- Reset release, memory word n = 16'h1000+n, no stall → `inst` 16'h1000, 16'h1001, 16'h1002 on consecutive cycles from cycle 3. `inst_pc` 0,2,4.
- `stall` high for 3 cycles while inst=16'h1002 → `inst` holds 16'h1002, `imem_en`=0 during the stall, 16'h1003 comes from the skid on the first free edge, 16'h1004 the next cycle. No instruction is lost or duplicated.
- `redirect`=1 with `redirect_pc`=16'h0041 while streaming → three bubble cycles, then `inst_pc`=16'h0040 with `inst`=word 0x20. The in-flight word is discarded.
- `redirect` and `stall` in the same cycle → flush taken, skid cleared, and the stream restarts at the redirect target once stall drops.
- `RESET_PC`=16'hFFFC → `inst_pc` sequence FFFC, FFFE, 0000, 0002.
- `reset` asserted mid-stall with skid valid → next cycle all outputs equal their reset values, and the restart fetches from RESET_PC.
